// File: rtl/nn_pkg.sv
// Shared neural-network layer definitions: FSM state encoding, default
// fixed-point format and the requantisation helper used by every dense layer.
// Optional feature macro: DENSE_LAYER_RELU_EN (ReLU before saturation).
package nn_pkg;

  // Default fixed-point format Q(W-FRAC).FRAC
  localparam int W_DEF    = 8;
  localparam int FRAC_DEF = 4;

  // Layer compute sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Floor-shift the accumulator back to the output format, optionally apply
  // ReLU, then saturate to the signed w-bit range. Works on a 64-bit signed
  // container so any accumulator up to 64 bits can share this one function;
  // the caller truncates the result to w bits, which is lossless after the clamp.
  function automatic logic signed [63:0] requant(input logic signed [63:0] acc,
                                                 input int frac,
                                                 input int w);
    logic signed [63:0] shifted;
    logic signed [63:0] maxVal;
    logic signed [63:0] minVal;
    shifted = acc >>> frac;
`ifdef DENSE_LAYER_RELU_EN
    if (shifted < 64'sd0) shifted = 64'sd0;
`endif
    maxVal = (64'sd1 <<< (w - 1)) - 64'sd1;
    minVal = -(64'sd1 <<< (w - 1));
    if (shifted > maxVal)      return maxVal;
    else if (shifted < minVal) return minVal;
    else                       return shifted;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Single signed multiply-accumulate: the accumulator is either loaded with a
// preset (bias) value or has the sign-extended W x W product added to it.
module mac_unit #(
  parameter int W     = 8,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic signed [ACC_W-1:0] loadVal_i,
  input  logic                    en_i,
  input  logic signed [W-1:0]     a_i,
  input  logic signed [W-1:0]     b_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [2*W-1:0]   product;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  assign product = a_i * b_i;

  // Load takes priority; otherwise accumulate the product when enabled
  always_comb begin
    acc_d = acc_q;
    if (load_i)    acc_d = loadVal_i;
    else if (en_i) acc_d = acc_q + ACC_W'(product);
  end

  // Accumulator register, cleared by reset so an aborted run leaves no residue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/dense_layer_mac.sv
// Fully-connected layer compute stage: one time-multiplexed signed MAC walks
// every neuron o and input i, computing requant(sum(w[o][i]*a[i]) + b[o]).
// Inputs are read live and must be held stable by the loaders until done.
// Optional feature macro: DENSE_LAYER_RELU_EN (ReLU in requant).
module dense_layer_mac
  import nn_pkg::*;
#(
  parameter int IN_SIZE  = 1,
  parameter int OUT_SIZE = 8,
  parameter int W        = W_DEF,
  parameter int FRAC     = FRAC_DEF,
  parameter int ACC_W    = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [IN_SIZE*W-1:0]         act_in,
  input  logic [IN_SIZE*OUT_SIZE*W-1:0] weights_in,
  input  logic [OUT_SIZE*W-1:0]        bias_in,
  output logic [OUT_SIZE*W-1:0]        data_out,
  output logic                         busy,
  output logic                         done
);

  localparam int I_CW = (IN_SIZE  > 1) ? $clog2(IN_SIZE)  : 1;
  localparam int O_CW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  // The accumulator must hold the worst-case sum without wrapping
  generate
    if ((ACC_W < 2*W + $clog2(IN_SIZE) + 1) || (ACC_W > 64)) begin : gAccWidthCheck
      $error("dense_layer_mac: ACC_W too small for W/IN_SIZE (or above 64)");
    end
  endgenerate

  state_e                  state_q, state_d;
  logic [O_CW-1:0]         neuronCnt_q, neuronCnt_d;
  logic [I_CW-1:0]         inputCnt_q, inputCnt_d;
  logic [OUT_SIZE*W-1:0]   dataOut_q;
  logic                    accLoad, accEn, writeEn;
  logic                    isLastInput, isLastNeuron;
  logic signed [W-1:0]     actSel, wSel, biasSel;
  logic signed [ACC_W-1:0] biasAcc, acc;
  logic [W-1:0]            result;

  // Operand selection from the live input buses by the current counters
  always_comb begin
    actSel  = act_in[int'(inputCnt_q)*W +: W];
    wSel    = weights_in[(int'(neuronCnt_q)*IN_SIZE + int'(inputCnt_q))*W +: W];
    biasSel = bias_in[int'(neuronCnt_q)*W +: W];
  end

  assign biasAcc      = ACC_W'(biasSel) <<< FRAC;
  assign isLastInput  = (int'(inputCnt_q)  == IN_SIZE - 1);
  assign isLastNeuron = (int'(neuronCnt_q) == OUT_SIZE - 1);
  assign result       = W'(requant(64'(acc), FRAC, W));

  mac_unit #(
    .W     (W),
    .ACC_W (ACC_W)
  ) uMac (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (accLoad),
    .loadVal_i (biasAcc),
    .en_i      (accEn),
    .a_i       (actSel),
    .b_i       (wSel),
    .acc_o     (acc)
  );

  // Sequencer next-state, counter updates and datapath strobes
  always_comb begin
    state_d     = state_q;
    neuronCnt_d = neuronCnt_q;
    inputCnt_d  = inputCnt_q;
    accLoad     = 1'b0;
    accEn       = 1'b0;
    writeEn     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          neuronCnt_d = '0;
        end
      end
      LOAD: begin
        accLoad    = 1'b1;
        inputCnt_d = '0;
        state_d    = MAC;
      end
      MAC: begin
        accEn = 1'b1;
        if (isLastInput) begin
          state_d = WRITE;
        end else begin
          inputCnt_d = inputCnt_q + I_CW'(1);
        end
      end
      WRITE: begin
        writeEn = 1'b1;
        if (isLastNeuron) begin
          state_d = DONE;
        end else begin
          neuronCnt_d = neuronCnt_q + O_CW'(1);
          state_d     = LOAD;
        end
      end
      DONE: begin
        if (start) begin
          state_d     = LOAD;
          neuronCnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      neuronCnt_q <= '0;
      inputCnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      neuronCnt_q <= neuronCnt_d;
      inputCnt_q  <= inputCnt_d;
    end
  end

  // Result register file, one neuron slot written per WRITE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataOut_q <= '0;
    end else if (writeEn) begin
      dataOut_q[int'(neuronCnt_q)*W +: W] <= result;
    end
  end

  assign data_out = dataOut_q;
  assign busy     = (state_q == LOAD) || (state_q == MAC) || (state_q == WRITE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_dense_layer_mac.sv
// Directed bench for dense_layer_mac: a 1-input/8-neuron instance and a
// 4-input/2-neuron instance sharing clock and reset.
// Expected values follow DENSE_LAYER_RELU_EN when it is defined.
module tb_dense_layer_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start1;
  logic [7:0]  act1;
  logic [63:0] w1, b1;
  logic [63:0] out1;
  logic        busy1, done1;

  logic        start4;
  logic [31:0] act4;
  logic [63:0] w4;
  logic [15:0] b4;
  logic [15:0] out4;
  logic        busy4, done4;

  int errors = 0;
  int checks = 0;

`ifdef DENSE_LAYER_RELU_EN
  localparam logic [7:0] EXP_NEG_SAT = 8'h00;
  localparam logic [7:0] EXP_SIGN    = 8'h00;
  localparam logic [7:0] EXP_FLOOR   = 8'h00;
`else
  localparam logic [7:0] EXP_NEG_SAT = 8'h80;
  localparam logic [7:0] EXP_SIGN    = 8'hE0;
  localparam logic [7:0] EXP_FLOOR   = 8'hFF;
`endif

  dense_layer_mac #(.IN_SIZE(1), .OUT_SIZE(8), .W(8), .FRAC(4), .ACC_W(24)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .act_in     (act1),
    .weights_in (w1),
    .bias_in    (b1),
    .data_out   (out1),
    .busy       (busy1),
    .done       (done1)
  );

  dense_layer_mac #(.IN_SIZE(4), .OUT_SIZE(2), .W(8), .FRAC(4), .ACC_W(24)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start4),
    .act_in     (act4),
    .weights_in (w4),
    .bias_in    (b4),
    .data_out   (out4),
    .busy       (busy4),
    .done       (done4)
  );

  // Pulse (or hold) start on dut1 and count edges until done, bounded
  task automatic run1(input bit holdStart, output int lat, output int busyCnt);
    lat = 0;
    busyCnt = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    if (!holdStart) start1 = 1'b0;
    while (done1 !== 1'b1 && lat < 200) begin
      if (busy1 === 1'b1) busyCnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    start1 = 1'b0;
  endtask

  task automatic applyStimulus1(input logic [7:0] a, input logic [7:0] w, input logic [7:0] b);
    act1 = a;
    w1   = {8{w}};
    b1   = {8{b}};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out1 !== 64'h0) begin errors++; $display("[TB] FAIL reset_out1: got %h expected 0", out1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy1: got %b expected 0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_done1: got %b expected 0", done1); end
    checks++; if (out4 !== 16'h0) begin errors++; $display("[TB] FAIL reset_out4: got %h expected 0", out4); end
    checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags4: got busy=%b done=%b expected 0/0", busy4, done4); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, busyCnt;
    applyStimulus1(8'h10, 8'h20, 8'h08);
    run1(1'b0, lat, busyCnt);
    checks++; if (lat !== 24) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 24", lat); end
    checks++; if (busyCnt !== 24) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 24", busyCnt); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_at_done: got %b expected 0", busy1); end
    for (int o = 0; o < 8; o++) begin
      checks++;
      if (out1[o*8 +: 8] !== 8'h28) begin errors++; $display("[TB] FAIL basic_out[%0d]: got %h expected 28", o, out1[o*8 +: 8]); end
    end
  endtask

  task automatic test_saturation();
    int lat, busyCnt;
    applyStimulus1(8'h7F, 8'h7F, 8'h7F);
    run1(1'b0, lat, busyCnt);
    checks++; if (out1 !== {8{8'h7F}}) begin errors++; $display("[TB] FAIL sat_pos: got %h expected all 7f", out1); end
    applyStimulus1(8'h80, 8'h7F, 8'h80);
    run1(1'b0, lat, busyCnt);
    checks++; if (out1 !== {8{EXP_NEG_SAT}}) begin errors++; $display("[TB] FAIL sat_neg: got %h expected all %h", out1, EXP_NEG_SAT); end
  endtask

  task automatic test_sign();
    int lat, busyCnt;
    applyStimulus1(8'h10, 8'hE0, 8'h00);
    run1(1'b0, lat, busyCnt);
    checks++; if (out1 !== {8{EXP_SIGN}}) begin errors++; $display("[TB] FAIL sign: got %h expected all %h", out1, EXP_SIGN); end
    applyStimulus1(8'h01, 8'hFF, 8'h00);
    run1(1'b0, lat, busyCnt);
    checks++; if (out1 !== {8{EXP_FLOOR}}) begin errors++; $display("[TB] FAIL floor_shift: got %h expected all %h", out1, EXP_FLOOR); end
  endtask

  task automatic test_bias_order();
    int lat, busyCnt;
    act1 = 8'h10;
    w1   = 64'h0;
    for (int o = 0; o < 8; o++) b1[o*8 +: 8] = 8'(o * 16);
    run1(1'b0, lat, busyCnt);
    for (int o = 0; o < 8; o++) begin
      checks++;
      if (out1[o*8 +: 8] !== 8'(o * 16)) begin errors++; $display("[TB] FAIL bias_out[%0d]: got %h expected %h", o, out1[o*8 +: 8], 8'(o * 16)); end
    end
  endtask

  task automatic test_restart_from_done();
    int lat;
    logic [63:0] prev;
    prev = out1;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    checks++; if (done1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("[TB] FAIL restart_flags: got done=%b busy=%b expected 0/1", done1, busy1); end
    checks++; if (out1 !== prev) begin errors++; $display("[TB] FAIL restart_hold_old: got %h expected %h", out1, prev); end
    lat = 0;
    while (done1 !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++; if (lat !== 24) begin errors++; $display("[TB] FAIL restart_latency: got %0d expected 24", lat); end
    checks++; if (out1 !== prev) begin errors++; $display("[TB] FAIL restart_results: got %h expected %h", out1, prev); end
  endtask

  task automatic test_start_held();
    int lat, busyCnt;
    applyStimulus1(8'h10, 8'h20, 8'h08);
    run1(1'b1, lat, busyCnt);
    checks++; if (lat !== 24) begin errors++; $display("[TB] FAIL held_latency: got %0d expected 24", lat); end
    repeat (3) @(negedge clk);
    checks++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("[TB] FAIL held_stay_done: got done=%b busy=%b expected 1/0", done1, busy1); end
    checks++; if (out1 !== {8{8'h28}}) begin errors++; $display("[TB] FAIL held_out: got %h expected all 28", out1); end
  endtask

  task automatic test_reset_mid();
    int lat, busyCnt;
    applyStimulus1(8'h10, 8'hE0, 8'h00);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #2;
    checks++; if (out1 !== 64'h0) begin errors++; $display("[TB] FAIL midreset_out: got %h expected 0", out1); end
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags: got busy=%b done=%b expected 0/0", busy1, done1); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL midreset_idle: got busy=%b expected 0", busy1); end
    applyStimulus1(8'h10, 8'h20, 8'h08);
    run1(1'b0, lat, busyCnt);
    checks++; if (lat !== 24) begin errors++; $display("[TB] FAIL midreset_latency: got %0d expected 24", lat); end
    checks++; if (out1 !== {8{8'h28}}) begin errors++; $display("[TB] FAIL midreset_out_after: got %h expected all 28", out1); end
  endtask

  task automatic test_multi_input();
    int lat;
    act4 = {4{8'h10}};
    w4   = {8'hF0, 8'h10, 8'hF0, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
    b4   = 16'h0;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    lat = 0;
    while (done4 !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++; if (lat !== 12) begin errors++; $display("[TB] FAIL multi_latency: got %0d expected 12", lat); end
    checks++; if (out4[7:0] !== 8'h40) begin errors++; $display("[TB] FAIL multi_out[0]: got %h expected 40", out4[7:0]); end
    checks++; if (out4[15:8] !== 8'h00) begin errors++; $display("[TB] FAIL multi_out[1]: got %h expected 00", out4[15:8]); end
  endtask

  initial begin
    start1 = 1'b0;
    start4 = 1'b0;
    act1 = '0; w1 = '0; b1 = '0;
    act4 = '0; w4 = '0; b4 = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_sign();
    test_bias_order();
    test_restart_from_done();
    test_start_held();
    test_reset_mid();
    test_multi_input();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
